// File: rtl/sys_array_result_streamer.sv
// Captures the ARRAY_W x ARRAY_W result matrix on a rising res_ready_i edge and streams it row-major over valid/ready.
// Optional macro SYS_ARRAY_STREAM_SAT_EN: signed saturation of each element to OUT_WIDTH instead of truncation.
module sys_array_result_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 4,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic                                                  res_ready_i,
  input  logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0]     res_data_i,
  output logic                                                  m_valid,
  input  logic                                                  m_ready,
  output logic [OUT_WIDTH-1:0]                                  m_data,
  output logic [$clog2(ARRAY_W)-1:0]                            m_row,
  output logic [$clog2(ARRAY_W)-1:0]                            m_col,
  output logic                                                  m_last,
  output logic                                                  busy,
  output logic                                                  overrun
);

  localparam int ELEM_W = 2 * DATA_WIDTH;
  localparam int NUM    = ARRAY_W * ARRAY_W;
  localparam int IDX_W  = $clog2(ARRAY_W);
  localparam int FLAT_W = $clog2(NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_W - 1);

`ifdef SYS_ARRAY_STREAM_SAT_EN
  localparam logic signed [ELEM_W-1:0] SAT_MAX =
    {{(ELEM_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ELEM_W-1:0] SAT_MIN =
    {{(ELEM_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
`endif

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  function automatic logic [OUT_WIDTH-1:0] conv_elem(input logic [ELEM_W-1:0] elem);
    logic [OUT_WIDTH-1:0] res;
`ifdef SYS_ARRAY_STREAM_SAT_EN
    if ($signed(elem) > SAT_MAX) begin
      res = SAT_MAX[OUT_WIDTH-1:0];
    end else if ($signed(elem) < SAT_MIN) begin
      res = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      res = elem[OUT_WIDTH-1:0];
    end
`else
    res = elem[OUT_WIDTH-1:0];
`endif
    return res;
  endfunction

  state_t                 state_reg, state_next;
  logic                   rdy_q_reg;
  logic [IDX_W-1:0]       row_reg, row_next;
  logic [IDX_W-1:0]       col_reg, col_next;
  logic                   m_valid_reg, m_valid_next;
  logic [OUT_WIDTH-1:0]   m_data_reg, m_data_next;
  logic                   m_last_reg, m_last_next;
  logic                   overrun_reg, overrun_next;
  logic                   load_shadow;

  logic [ELEM_W-1:0]      shadow_reg [0:NUM-1];
  logic [OUT_WIDTH-1:0]   conv_shadow [0:NUM-1];

  logic                   capture_ev;
  logic                   handshake;
  logic [IDX_W-1:0]       row_step, col_step;
  logic [FLAT_W-1:0]      step_idx;
  logic [OUT_WIDTH-1:0]   step_data;
  logic                   step_last;
  logic [OUT_WIDTH-1:0]   first_data;

  assign capture_ev = res_ready_i & ~rdy_q_reg;
  assign handshake  = m_valid_reg & m_ready;

  // Shadow is pure datapath: no reset needed, only ever read after a capture.
  always_ff @(posedge clk) begin
    if (load_shadow) begin
      for (int i = 0; i < NUM; i++) begin
        shadow_reg[i] <= res_data_i[i / ARRAY_W][i % ARRAY_W];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_conv
      assign conv_shadow[gi] = conv_elem(shadow_reg[gi]);
    end
  endgenerate

  // Position of the element that follows the current one.
  assign col_step  = (col_reg == LAST_IDX) ? '0 : col_reg + 1'b1;
  assign row_step  = (col_reg == LAST_IDX) ? row_reg + 1'b1 : row_reg;
  assign step_idx  = FLAT_W'(row_step) * FLAT_W'(ARRAY_W) + FLAT_W'(col_step);
  assign step_data = conv_shadow[step_idx];
  assign step_last = (row_step == LAST_IDX) && (col_step == LAST_IDX);

  // Element [0][0] bypasses the shadow so the first beat appears one cycle after capture.
  assign first_data = conv_elem(res_data_i[0][0]);

  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;
    m_last_next  = m_last_reg;
    overrun_next = overrun_reg;
    load_shadow  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (capture_ev) begin
          load_shadow  = 1'b1;
          state_next   = ST_STREAM;
          row_next     = '0;
          col_next     = '0;
          m_valid_next = 1'b1;
          m_data_next  = first_data;
          m_last_next  = 1'b0;
        end
      end
      ST_STREAM: begin
        if (handshake && m_last_reg) begin
          if (capture_ev) begin
            load_shadow  = 1'b1;
            row_next     = '0;
            col_next     = '0;
            m_valid_next = 1'b1;
            m_data_next  = first_data;
            m_last_next  = 1'b0;
          end else begin
            state_next   = ST_IDLE;
            row_next     = '0;
            col_next     = '0;
            m_valid_next = 1'b0;
            m_data_next  = '0;
            m_last_next  = 1'b0;
          end
        end else begin
          if (capture_ev) begin
            overrun_next = 1'b1;
          end
          if (handshake) begin
            row_next    = row_step;
            col_next    = col_step;
            m_data_next = step_data;
            m_last_next = step_last;
          end
        end
      end
      default: begin
        state_next   = ST_IDLE;
        m_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      rdy_q_reg   <= 1'b1;
      row_reg     <= '0;
      col_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_last_reg  <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rdy_q_reg   <= res_ready_i;
      row_reg     <= row_next;
      col_reg     <= col_next;
      m_valid_reg <= m_valid_next;
      m_data_reg  <= m_data_next;
      m_last_reg  <= m_last_next;
      overrun_reg <= overrun_next;
    end
  end

  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;
  assign m_row   = row_reg;
  assign m_col   = col_reg;
  assign m_last  = m_last_reg;
  assign busy    = (state_reg == ST_STREAM);
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_sys_array_result_streamer.sv
// Bench for sys_array_result_streamer: a 16-bit and a 12-bit output instance driven in lockstep against a queue model.
module tb_sys_array_result_streamer;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic res_ready = 1'b0;
  logic [0:3][0:3][15:0] res_data = '0;
  logic m_ready = 1'b0;

  logic        m_valid_a, m_last_a, busy_a, overrun_a;
  logic [15:0] m_data_a;
  logic [1:0]  m_row_a, m_col_a;
  logic        m_valid_b, m_last_b, busy_b, overrun_b;
  logic [11:0] m_data_b;
  logic [1:0]  m_row_b, m_col_b;

  always #5 clk = ~clk;

  sys_array_result_streamer #(.DATA_WIDTH(8), .ARRAY_W(4), .OUT_WIDTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .res_ready_i(res_ready), .res_data_i(res_data),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_row(m_row_a),
    .m_col(m_col_a), .m_last(m_last_a), .busy(busy_a), .overrun(overrun_a));

  sys_array_result_streamer #(.DATA_WIDTH(8), .ARRAY_W(4), .OUT_WIDTH(12)) dut_b (
    .clk(clk), .reset_n(reset_n), .res_ready_i(res_ready), .res_data_i(res_data),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_row(m_row_b),
    .m_col(m_col_b), .m_last(m_last_b), .busy(busy_b), .overrun(overrun_b));

  typedef struct {
    logic [15:0] d16;
    logic [11:0] d12;
    int          row;
    int          col;
    bit          last;
  } beat_t;

  beat_t q[$];
  bit    ovr_model = 0;
  bit    prev_rdy = 1;
  int    errors = 0;
  int    checks = 0;

  // Expected 12-bit element from a 16-bit signed value.
  function automatic logic [11:0] conv12(input logic [15:0] e);
    int v;
`ifdef SYS_ARRAY_STREAM_SAT_EN
    v = int'($signed(e));
    if (v > 2047) v = 2047;
    else if (v < -2048) v = -2048;
`else
    v = int'(e);
`endif
    return v[11:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_matrix();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        beat_t b;
        b.d16  = res_data[r][c];
        b.d12  = conv12(res_data[r][c]);
        b.row  = r;
        b.col  = c;
        b.last = (r == 3) && (c == 3);
        q.push_back(b);
      end
    end
  endtask

  // Compare outputs against the model, advance the model by this cycle's inputs, then clock.
  task automatic tick();
    bit v;
    v = (q.size() != 0);
    check("a_valid", m_valid_a, v);
    check("b_valid", m_valid_b, v);
    check("a_busy", busy_a, v);
    check("b_busy", busy_b, v);
    check("a_overrun", overrun_a, ovr_model);
    check("b_overrun", overrun_b, ovr_model);
    if (v) begin
      check("a_data", m_data_a, q[0].d16);
      check("b_data", m_data_b, q[0].d12);
      check("a_row", m_row_a, q[0].row);
      check("a_col", m_col_a, q[0].col);
      check("a_last", m_last_a, q[0].last);
      check("b_row", m_row_b, q[0].row);
      check("b_col", m_col_b, q[0].col);
      check("b_last", m_last_b, q[0].last);
    end else begin
      check("a_idle_pos", {m_row_a, m_col_a, m_last_a}, 0);
      check("b_idle_pos", {m_row_b, m_col_b, m_last_b}, 0);
    end
    $display("t=%0t rdy=%0b mrdy=%0b a:v=%0b d=%h r=%0d c=%0d l=%0b ov=%0b b:d=%h pending=%0d",
             $time, res_ready, m_ready, m_valid_a, m_data_a, m_row_a, m_col_a, m_last_a,
             overrun_a, m_data_b, q.size());
    if (reset_n) begin
      if (v && m_ready) void'(q.pop_front());
      if (res_ready && !prev_rdy) begin
        if (q.size() == 0) push_matrix();
        else ovr_model = 1;
      end
      prev_rdy = res_ready;
    end else begin
      prev_rdy = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_done", q.size(), 0);
    tick();
  endtask

  task automatic pulse_capture();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic load_ramp();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res_data[r][c] = 16'(16 * r + c);
  endtask

  initial begin
    // Reset and reset-state checks
    #2 reset_n = 1'b0;
    #2;
    check("rst_valid", m_valid_a, 0);
    check("rst_data_a", m_data_a, 0);
    check("rst_data_b", m_data_b, 0);
    check("rst_pos", {m_row_a, m_col_a, m_last_a}, 0);
    check("rst_busy_ovr", {busy_a, overrun_a, busy_b, overrun_b}, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Ramp matrix, full-rate drain
    load_ramp();
    m_ready = 1'b1;
    pulse_capture();
    drain(40);

    // Ramp matrix with 1,0,0 ready pattern
    pulse_capture();
    for (int k = 0; k < 80 && q.size() != 0; k++) begin
      m_ready = (k % 3 == 0);
      tick();
    end
    check("stall_drain", q.size(), 0);
    m_ready = 1'b1;
    tick();

    // Overlapping edge during beat 5 is ignored and flagged
    pulse_capture();
    while (q.size() > 12) tick();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res_data[r][c] = 16'($urandom);
    pulse_capture();
    drain(40);
    tick();

    // Asynchronous reset at beat 7, then held-high ready must not start a stream
    load_ramp();
    pulse_capture();
    while (q.size() > 10) tick();
    reset_n = 1'b0;
    #1;
    check("arst_valid", m_valid_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_overrun", overrun_a, 0);
    q.delete();
    ovr_model = 0;
    prev_rdy = 1;
    res_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    res_ready = 1'b0;
    tick();
    pulse_capture();
    drain(40);

    // New edge aligned with the final handshake: no bubble
    load_ramp();
    pulse_capture();
    while (q.size() > 1) tick();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res_data[r][c] = 16'h00AA;
    pulse_capture();
    check("b2b_valid", m_valid_a, 1);
    check("b2b_data", m_data_a, 16'h00AA);
    check("b2b_pos", {m_row_a, m_col_a}, 0);
    check("b2b_overrun", overrun_a, 0);
    drain(40);

    // Saturation/truncation corner values on the 12-bit instance
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res_data[r][c] = 16'($urandom);
    res_data[0][0] = 16'h7FFF;
    res_data[0][1] = 16'h8000;
    res_data[0][2] = 16'h0123;
    res_data[0][3] = 16'hFF00;
    pulse_capture();
`ifdef SYS_ARRAY_STREAM_SAT_EN
    check("sat_7fff", m_data_b, 12'h7FF);
`else
    check("trunc_7fff", m_data_b, 12'hFFF);
`endif
    tick();
`ifdef SYS_ARRAY_STREAM_SAT_EN
    check("sat_8000", m_data_b, 12'h800);
`else
    check("trunc_8000", m_data_b, 12'h000);
`endif
    drain(40);

    // Randomized jobs with random backpressure
    for (int k = 0; k < 600; k++) begin
      m_ready = ($urandom_range(0, 9) < 7);
      if (res_ready) begin
        res_ready = ($urandom_range(0, 1) == 1);
      end else begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            res_data[r][c] = 16'($urandom);
        res_ready = ($urandom_range(0, 15) == 0);
      end
      tick();
    end
    res_ready = 1'b0;
    m_ready = 1'b1;
    drain(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
